// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, drives the instruction ROM and
// buffers fetched {pc, inst} pairs in a small prefetch queue for decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W     = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Elaboration-time parameter sanity
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_fetch: QUEUE_DEPTH must be a power of 2 and >= 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("inst_fetch: RESET_PC must be word aligned");
    end

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      q_pc_q   [QUEUE_DEPTH];
    logic [31:0]      q_pc_d   [QUEUE_DEPTH];
    logic [31:0]      q_inst_q [QUEUE_DEPTH];
    logic [31:0]      q_inst_d [QUEUE_DEPTH];

    logic head_valid;
    logic pop;
    logic push;

    // Handshake and fetch-enable decisions
    always_comb begin
        head_valid = (count_q != CNT_W'(0));
        pop        = ~rst & head_valid & id_ready & ~br_taken;
        push       = ~rst & ~br_taken & ((count_q < CNT_W'(QUEUE_DEPTH)) | pop);
    end

    assign rom_ce   = push;
    assign rom_addr = pc_q;

    // Head presentation; zeroed while empty or held in reset
    always_comb begin
        id_valid = ~rst & head_valid;
        id_pc    = ZERO_WORD;
        id_inst  = ZERO_WORD;
        if (id_valid) begin
            id_pc   = q_pc_q[rd_ptr_q];
            id_inst = q_inst_q[rd_ptr_q];
        end
    end

    // Next-state: redirect flushes everything, otherwise push/pop bookkeeping
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_pc_d   = q_pc_q;
        q_inst_d = q_inst_q;

        if (br_taken) begin
            pc_d     = br_target & ~32'h0000_0003;
            count_d  = CNT_W'(0);
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
        end else begin
            if (push) begin
                q_pc_d[wr_ptr_q]   = pc_q;
                q_inst_d[wr_ptr_q] = rom_inst;
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
                pc_d               = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= CNT_W'(0);
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q_pc_q[i]   <= ZERO_WORD;
                q_inst_q[i] <= ZERO_WORD;
            end
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            q_pc_q   <= q_pc_d;
            q_inst_q <= q_inst_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle checks plus a scoreboard of expected
// decode handshakes; a second instance exercises PC wrap-around.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_ready;

    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    logic        w_rom_ce;
    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_inst;
    logic        w_id_valid;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_inst;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_id_ready;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // ROM: word k holds 0x1000_0000 + k; reads zero while disabled
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign rom_inst   = rom_ce   ? rom_word(rom_addr)   : 32'h0;
    assign w_rom_inst = w_rom_ce ? rom_word(w_rom_addr) : 32'h0;

    assign w_br_taken  = 1'b0;
    assign w_br_target = 32'h0;
    assign w_id_ready  = 1'b1;

    inst_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .br_taken(br_taken), .br_target(br_target), .id_ready(id_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst), .rom_ce(w_rom_ce), .rom_addr(w_rom_addr), .rom_inst(w_rom_inst),
        .br_taken(w_br_taken), .br_target(w_br_target), .id_ready(w_id_ready),
        .id_valid(w_id_valid), .id_pc(w_id_pc), .id_inst(w_id_inst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted decode handshake must match the next expected pc
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready && !br_taken) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", id_pc, 32'hDEAD_BEEF);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                chk("sb_pc", id_pc, e);
                chk("sb_inst", id_inst, rom_word(e));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        id_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;

        // Reset
        @(negedge clk);
        chk("rst_rom_ce", 32'(rom_ce), 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        step();
        @(negedge clk);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_w_rom_addr", w_rom_addr, 32'hFFFF_FFF8);
        step();

        // Stream, redirect mid-stream, redirect while full and stalled
        rst = 1'b0; id_ready = 1'b1;
        exp_q.push_back(32'h0);   exp_q.push_back(32'h4);   exp_q.push_back(32'h8);
        exp_q.push_back(32'h40);  exp_q.push_back(32'h44);
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        @(negedge clk);
        chk("c0_rom_ce", 32'(rom_ce), 32'h1);
        chk("c0_rom_addr", rom_addr, 32'h0);
        chk("c0_id_valid", 32'(id_valid), 32'h0);
        step();
        @(negedge clk);
        chk("c1_id_valid", 32'(id_valid), 32'h1);
        chk("c1_id_pc", id_pc, 32'h0);
        chk("c1_id_inst", id_inst, 32'h1000_0000);
        chk("wrap_valid", 32'(w_id_valid), 32'h1);
        chk("wrap_pc0", w_id_pc, 32'hFFFF_FFF8);
        step();
        @(negedge clk);
        chk("c2_id_pc", id_pc, 32'h4);
        chk("wrap_pc1", w_id_pc, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        chk("c3_id_pc", id_pc, 32'h8);
        chk("c3_rom_addr", rom_addr, 32'hC);
        chk("wrap_pc2", w_id_pc, 32'h0000_0000);
        chk("wrap_inst2", w_id_inst, 32'h1000_0000);
        step();
        br_taken = 1'b1; br_target = 32'h0000_0043;
        @(negedge clk);
        chk("br_rom_ce", 32'(rom_ce), 32'h0);
        chk("br_id_pc_preflush", id_pc, 32'hC);
        chk("wrap_pc3", w_id_pc, 32'h0000_0004);
        step();
        br_taken = 1'b0;
        @(negedge clk);
        chk("br1_id_valid", 32'(id_valid), 32'h0);
        chk("br1_rom_addr", rom_addr, 32'h40);
        chk("br1_rom_ce", 32'(rom_ce), 32'h1);
        step();
        @(negedge clk);
        chk("br2_id_pc", id_pc, 32'h40);
        step();
        step();
        id_ready = 1'b0;
        @(negedge clk);
        chk("stall_fill_rom_addr", rom_addr, 32'h4C);
        step();
        br_taken = 1'b1; br_target = 32'h0000_0200;
        @(negedge clk);
        chk("full_id_valid", 32'(id_valid), 32'h1);
        chk("full_id_pc", id_pc, 32'h48);
        chk("full_rom_addr", rom_addr, 32'h50);
        step();
        br_taken = 1'b0;
        @(negedge clk);
        chk("fbr1_id_valid", 32'(id_valid), 32'h0);
        chk("fbr1_rom_addr", rom_addr, 32'h200);
        chk("fbr1_rom_ce", 32'(rom_ce), 32'h1);
        step();
        id_ready = 1'b1;
        @(negedge clk);
        chk("fbr2_id_pc", id_pc, 32'h200);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_id_valid", 32'(id_valid), 32'h0);
        step();
        chk("sb_drain1", 32'(exp_q.size()), 32'h0);

        // Backpressure, pop-and-fetch while full, reset mid-operation
        rst = 1'b0; id_ready = 1'b0;
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("bp0_rom_ce", 32'(rom_ce), 32'h1);
        chk("bp0_rom_addr", rom_addr, 32'h0);
        step();
        @(negedge clk);
        chk("bp1_rom_ce", 32'(rom_ce), 32'h1);
        chk("bp1_rom_addr", rom_addr, 32'h4);
        chk("bp1_id_pc", id_pc, 32'h0);
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_full_rom_ce", 32'(rom_ce), 32'h0);
            chk("bp_full_rom_addr", rom_addr, 32'h8);
            chk("bp_full_id_pc", id_pc, 32'h0);
            step();
        end
        id_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_rom_ce", 32'(rom_ce), 32'h1);
        chk("bp_pop_rom_addr", rom_addr, 32'h8);
        step();
        id_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_valid", 32'(id_valid), 32'h1);
        chk("bp_after_id_pc", id_pc, 32'h4);
        chk("bp_after_rom_ce", 32'(rom_ce), 32'h0);
        chk("bp_after_rom_addr", rom_addr, 32'hC);
        step();
        rst = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        chk("mrst_id_valid", 32'(id_valid), 32'h0);
        chk("mrst_rom_ce", 32'(rom_ce), 32'h0);
        chk("mrst_id_pc", id_pc, 32'h0);
        step();
        @(negedge clk);
        chk("mrst2_id_valid", 32'(id_valid), 32'h0);
        chk("mrst2_rom_ce", 32'(rom_ce), 32'h0);
        chk("mrst2_rom_addr", rom_addr, 32'h0);
        step();
        rst = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        @(negedge clk);
        chk("rs_rom_ce", 32'(rom_ce), 32'h1);
        chk("rs_rom_addr", rom_addr, 32'h0);
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("sb_drain2", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
